// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, FSM states, op decode.
package mdu_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef logic [1:0] op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_e;

    typedef struct packed {
        logic is_div;
        logic is_signed;
    } op_dec_t;

    // Split an op code into its divide/signed attributes.
    function automatic op_dec_t op_decode(input op_t op);
        op_dec_t d;
        d = '0;
        case (op)
            OP_MULTU: begin d.is_div = 1'b0; d.is_signed = 1'b0; end
            OP_MULT:  begin d.is_div = 1'b0; d.is_signed = 1'b1; end
            OP_DIVU:  begin d.is_div = 1'b1; d.is_signed = 1'b0; end
            OP_DIV:   begin d.is_div = 1'b1; d.is_signed = 1'b1; end
            default:  d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response and HI/LO access bundle between the execute stage and the unit.
interface mul_div_unit_if
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
);

    logic             i_start;
    op_t              i_op;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_cancel;
    logic             i_hi_we;
    logic             i_lo_we;
    logic [WIDTH-1:0] i_hi_wd;
    logic [WIDTH-1:0] i_lo_wd;
    logic             o_busy;
    logic             o_done;
    logic             o_divzero;
    logic [WIDTH-1:0] o_hi;
    logic [WIDTH-1:0] o_lo;

    modport master (
        output i_start, i_op, i_a, i_b, i_cancel, i_hi_we, i_lo_we, i_hi_wd, i_lo_wd,
        input  o_busy, o_done, o_divzero, o_hi, o_lo
    );

    modport slave (
        input  i_start, i_op, i_a, i_b, i_cancel, i_hi_we, i_lo_we, i_hi_wd, i_lo_wd,
        output o_busy, o_done, o_divzero, o_hi, o_lo
    );

endinterface

// File: rtl/cond_negate.sv
// Conditional two's-complement negate of a WIDTH-bit value.
module cond_negate #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_val
);

    localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

    // Negate when requested, pass through otherwise.
    always_comb begin
        o_val = i_neg ? (~i_val + One) : i_val;
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers; one iteration per cycle.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
    input logic           clk,
    input logic           reset,
    mul_div_unit_if.slave mdu
);

    state_e             r_state;
    logic               r_is_div;
    logic               r_sa;
    logic               r_sb;
    logic               r_dz;
    logic [WIDTH-1:0]   r_ma;
    logic [WIDTH-1:0]   r_mb;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_divzero;

    op_dec_t            w_dec;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [2*WIDTH-1:0] w_mul_add;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_rem_sub;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // Decode the incoming request and derive operand signs.
    always_comb begin
        w_dec = op_decode(mdu.i_op);
        w_sa  = w_dec.is_signed & mdu.i_a[WIDTH-1];
        w_sb  = w_dec.is_signed & mdu.i_b[WIDTH-1];
    end

    cond_negate #(.WIDTH(WIDTH)) u_abs_a (
        .i_val (mdu.i_a),
        .i_neg (w_sa),
        .o_val (w_abs_a)
    );

    cond_negate #(.WIDTH(WIDTH)) u_abs_b (
        .i_val (mdu.i_b),
        .i_neg (w_sb),
        .o_val (w_abs_b)
    );

    // One iteration of each algorithm. Multiply consumes the multiplier MSB-first;
    // divide shifts the next dividend bit into the partial remainder.
    always_comb begin
        w_mul_add  = r_mb[WIDTH-1] ? {{WIDTH{1'b0}}, r_ma} : '0;
        w_mul_next = {r_acc[2*WIDTH-2:0], 1'b0} + w_mul_add;

        // Shifted remainder needs one extra bit before the trial subtract.
        w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_ma[WIDTH-1]};
        w_div_ge   = (w_rem_sh >= {1'b0, r_mb});
        // Only used when the trial succeeds, so the result always fits WIDTH bits.
        w_rem_sub  = w_rem_sh[WIDTH-1:0] - r_mb;
        w_div_next = {(w_div_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0]),
                      r_acc[WIDTH-2:0], w_div_ge};
    end

    cond_negate #(.WIDTH(2 * WIDTH)) u_fix_prod (
        .i_val (r_acc),
        .i_neg (r_sa ^ r_sb),
        .o_val (w_prod_fix)
    );

    cond_negate #(.WIDTH(WIDTH)) u_fix_quot (
        .i_val (r_acc[WIDTH-1:0]),
        .i_neg (r_sa ^ r_sb),
        .o_val (w_quot_fix)
    );

    // Remainder takes the sign of the dividend.
    cond_negate #(.WIDTH(WIDTH)) u_fix_rem (
        .i_val (r_acc[2*WIDTH-1:WIDTH]),
        .i_neg (r_sa),
        .o_val (w_rem_fix)
    );

    // Control FSM plus datapath registers; done/divzero are single-cycle pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_is_div  <= 1'b0;
            r_sa      <= 1'b0;
            r_sb      <= 1'b0;
            r_dz      <= 1'b0;
            r_ma      <= '0;
            r_mb      <= '0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (mdu.i_hi_we) r_hi <= mdu.i_hi_wd;
                    if (mdu.i_lo_we) r_lo <= mdu.i_lo_wd;
                    if (mdu.i_start) begin
                        r_state  <= CALC;
                        r_is_div <= w_dec.is_div;
                        r_sa     <= w_sa;
                        r_sb     <= w_sb;
                        r_ma     <= w_abs_a;
                        r_mb     <= w_abs_b;
                        r_dz     <= w_dec.is_div && (mdu.i_b == '0);
                        r_cnt    <= '0;
                        r_acc    <= '0;
                    end
                end
                CALC: begin
                    if (mdu.i_cancel) begin
                        r_state <= IDLE;
                    end else begin
                        if (r_is_div) begin
                            r_acc <= w_div_next;
                            r_ma  <= r_ma << 1;
                        end else begin
                            r_acc <= w_mul_next;
                            r_mb  <= r_mb << 1;
                        end
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == CW'(WIDTH - 1)) r_state <= FIX;
                    end
                end
                FIX: begin
                    r_state <= IDLE;
                    if (!mdu.i_cancel) begin
                        if (r_is_div) begin
                            // A zero divisor leaves HI = dividend via the remainder path.
                            r_lo <= r_dz ? {WIDTH{1'b1}} : w_quot_fix;
                            r_hi <= w_rem_fix;
                        end else begin
                            r_lo <= w_prod_fix[WIDTH-1:0];
                            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        end
                        r_done    <= 1'b1;
                        r_divzero <= r_dz;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Status and architectural registers straight from flops.
    always_comb begin
        mdu.o_busy    = (r_state != IDLE);
        mdu.o_done    = r_done;
        mdu.o_divzero = r_divzero;
        mdu.o_hi      = r_hi;
        mdu.o_lo      = r_lo;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle integer multiply/divide unit with architectural HI/LO result registers. It is the parametrised successor to the single-cycle ALU multiply path. The unit sits beside the ALU in the execute stage. It accepts a signed or unsigned multiply or divide request, iterates one bit per cycle, and exposes HI/LO for move-from reads. It also supports direct HI/LO writes for move-to instructions.

## Interface
Parameters:
- WIDTH, default 32: operand and HI/LO width; must be at least 4.
- CW, default $clog2(WIDTH+1): iteration counter width (derived).

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- reset, input, 1: asynchronous, active-low reset.
- start, input, 1: request a new operation; sampled only in IDLE.
- op, input, 2: operation select. 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- a, input, WIDTH: multiplicand or dividend (rs).
- b, input, WIDTH: multiplier or divisor (rt).
- cancel, input, 1: abort the operation in flight.
- hi_we, input, 1: write hi_wd into HI (mthi).
- lo_we, input, 1: write lo_wd into LO (mtlo).
- hi_wd, input, WIDTH: HI write data.
- lo_wd, input, WIDTH: LO write data.
- busy, output, 1: operation in flight (CALC or FIX).
- done, output, 1: one-cycle pulse when HI/LO take a new result.
- divzero, output, 1: valid with done; divisor was zero.
- hi, output, WIDTH: HI register.
- lo, output, WIDTH: LO register.

## Operation
- States:
  - IDLE: wait for start.
  - CALC: WIDTH iterations.
  - FIX: sign correction and write-back.
- IDLE → CALC on start:
  - Latch op, sign flags (signed ops only), and operand magnitudes (two's-complement absolute values for signed ops).
  - Clear the counter and the accumulator.
- CALC, one step per cycle:
  - Multiply: shift-add, 2·WIDTH-bit partial product.
  - Divide: restoring shift-subtract, WIDTH-bit partial remainder and quotient.
  - After WIDTH steps, go to FIX.
- FIX → IDLE:
  - Multiply: 2·WIDTH product, negated if sa^sb. HI = upper half, LO = lower half.
  - Divide: LO = quotient, negated if sa^sb. HI = remainder, negated if sa (remainder sign follows dividend).
  - Pulse done.
- Divide by zero:
  - LO = all ones and HI = a, exactly as given, for both DIV and DIVU.
  - divzero = 1 with done.
- Signed overflow: DIV of most-negative by −1 gives LO = most-negative and HI = 0. This is the natural wrap; no flag.
- start while busy is ignored. There is no queueing.
- cancel in CALC or FIX:
  - Go to IDLE on the next edge.
  - HI/LO are unchanged and no done is pulsed.
  - cancel in IDLE has no effect.
- hi_we/lo_we:
  - Honoured only in IDLE; ignored while busy.
  - In IDLE with start in the same cycle, the write takes effect and the operation is also accepted. The later result overwrites the written value.
- Arithmetic is modulo 2^WIDTH per half. There are no exceptions.

## Timing
- Reset values: state IDLE, busy 0, done 0, divzero 0, hi 0, lo 0, counter 0.
- Edge E0 samples start. busy = 1 from after E0 through E_{WIDTH+1}.
- E1…E_WIDTH perform the iterations. FIX is the cycle after E_WIDTH.
- E_{WIDTH+1} writes HI/LO. done = 1 and divzero are valid for exactly the cycle after E_{WIDTH+1}, with busy = 0.
- Latency from start to results visible is WIDTH+2 cycles; throughput is one operation per WIDTH+2 cycles.
- A new start is accepted in the same cycle that done is high.
- Asserting reset mid-operation forces all reset values immediately. The pending result is lost.
- hi and lo are registered outputs. The intermediate accumulator is never visible on them.

## Structure
- Shared package mdu_pkg holds:
  - Op encoding constants: OP_MULTU, OP_MULT, OP_DIVU, OP_DIV.
  - State enum: IDLE, CALC, FIX.
- One sub-module is natural: cond_negate. It is a parametrised-width conditional two's-complement negate. Instantiate it for operand magnitude and for result correction at WIDTH and 2·WIDTH.
- The datapath and FSM live in a single module otherwise.

## Test plan
All scenarios use WIDTH = 32.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001. done exactly 34 cycles after the start cycle; busy high 33 cycles.
- MULT −3 × 5 → hi = 0xFFFFFFFF, lo = 0xFFFFFFF1. MULT 0x80000000 × 0x80000000 → hi = 0x40000000, lo = 0.
- DIV −7 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIVU 100 / 7 → lo = 14, hi = 2. DIV 0x80000000 / −1 → lo = 0x80000000, hi = 0.
- DIVU 100 / 0 → lo = 0xFFFFFFFF, hi = 100, divzero = 1 with done. The next operation has divzero = 0.
- Control interactions:
  - cancel at iteration 10 → no done, HI/LO keep their prior values.
  - start while busy is ignored.
  - hi_we while busy is ignored.
  - hi_we in IDLE with hi_wd = 0x1234 → hi = 0x1234 next cycle.
- Reset (low) asserted mid-CALC → busy, hi, and lo are 0 immediately. After release, a fresh MULTU 6 × 7 gives lo = 42.
